// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared state encoding and default constants for the SD SPI command engine
package sd_spi_pkg;
    localparam int CMD_BITS      = 48;
    localparam int INIT_CLKS_DEF = 80;
    localparam int NCR_MAX_DEF   = 8;
    localparam int CNT_W         = 16;
    typedef enum logic [2:0] {INIT, IDLE, SEND, WAIT_R, RECV, TAIL} state_t;
endpackage

// File: rtl/sd_spi_shift.sv
// sd_spi_shift: 8-bit MSB-first shift register with bit counter, shared by TX and RX
module sd_spi_shift (
    input  logic       clk,
    input  logic       res_n,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       shift,
    input  logic       sin,
    output logic [7:0] q,
    output logic       last
);
    logic [2:0] cnt;
    assign last = cnt == 3'd7;
    // load restarts the byte; shift moves one bit and wraps the counter every 8 bits
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            q   <= 8'h00;
            cnt <= 3'd0;
        end else if (load) begin
            q   <= din;
            cnt <= 3'd0;
        end else if (shift) begin
            q   <= {q[6:0], sin};
            cnt <= cnt + 3'd1;
        end
    end
endmodule

// File: rtl/sd_spi_out_init.sv
// sd_spi_out_init: SD card SPI power-up, command send and response capture (optional timeout: SD_SPI_TIMEOUT_EN)
module sd_spi_out_init
    import sd_spi_pkg::*;
#(
    parameter int INIT_CLKS = INIT_CLKS_DEF,
    parameter int NCR_MAX   = NCR_MAX_DEF
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic [CMD_BITS-1:0] spi_cmd_data,
    input  logic                spi_cmd,
    input  logic [9:0]          spi_bytes_expected,
    output logic                spi_busy,
    output logic                spi_error,
    output logic [7:0]          spi_response,
    output logic                spi_avail,
    output logic                card_MOSI,
    input  logic                card_MISO,
    output logic                card_CS
);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(8 * NCR_MAX - 1);
    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [CMD_BITS-9:0]   frame;
    logic [9:0]            nbytes;
    logic [7:0]            sh_q, sh_din;
    logic                  sh_last, sh_load, sh_shift;
    logic                  accept, byte_done, rx_last, timeout;

    sd_spi_shift u_shift (
        .clk   (clk),
        .res_n (res_n),
        .load  (sh_load),
        .din   (sh_din),
        .shift (sh_shift),
        .sin   (card_MISO),
        .q     (sh_q),
        .last  (sh_last)
    );

    assign accept    = state == IDLE && spi_cmd;
    assign byte_done = state == RECV && sh_last;
    assign rx_last   = byte_done && cnt + CNT_W'(1) == CNT_W'(nbytes);
    assign spi_busy  = state != IDLE;
    assign card_CS   = !(state == SEND || state == WAIT_R || state == RECV);
    assign card_MOSI = state == SEND ? sh_q[7] : 1'b1;

`ifdef SD_SPI_TIMEOUT_EN
    logic err_q;
    assign timeout   = state == WAIT_R && card_MISO && cnt == TO_LAST;
    assign spi_error = err_q;
    // error is raised by a response timeout and cleared only by the next accepted command
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) err_q <= 1'b0;
        else if (accept) err_q <= 1'b0;
        else if (timeout) err_q <= 1'b1;
    end
`else
    assign timeout   = 1'b0 && cnt == TO_LAST;
    assign spi_error = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= INIT;
        else state <= state_n;
    end

    // next state and shifter control; a zero MISO bit in WAIT_R is already bit 7 of the first byte
    always_comb begin
        state_n  = state;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = 8'h00;
        case (state)
            INIT:   if (cnt == CNT_W'(INIT_CLKS - 1)) state_n = IDLE;
            IDLE:   if (spi_cmd) begin
                        state_n = SEND;
                        sh_load = 1'b1;
                        sh_din  = spi_cmd_data[CMD_BITS-1 -: 8];
                    end
            SEND:   if (sh_last) begin
                        sh_load = 1'b1;
                        sh_din  = frame[CMD_BITS-9 -: 8];
                        if (cnt == CNT_W'(CMD_BITS / 8 - 1)) begin
                            sh_din  = 8'h00;
                            state_n = nbytes == 10'd0 ? TAIL : WAIT_R;
                        end
                    end else sh_shift = 1'b1;
            WAIT_R: if (!card_MISO) begin
                        sh_shift = 1'b1;
                        state_n  = RECV;
                    end else if (timeout) state_n = TAIL;
            RECV:   begin
                        sh_shift = 1'b1;
                        if (rx_last) state_n = TAIL;
                    end
            TAIL:   if (cnt == CNT_W'(7)) state_n = IDLE;
            default: state_n = INIT;
        endcase
    end

    // cnt restarts on every state change; it counts bytes in SEND/RECV and clocks elsewhere
    always_comb begin
        cnt_n = state_n != state ? '0 :
                state == SEND    ? cnt + CNT_W'(sh_last) :
                state == RECV    ? cnt + CNT_W'(byte_done) :
                state == IDLE    ? '0 : cnt + CNT_W'(1);
    end

    // datapath: counter, latched command, received byte and its strobe
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt          <= '0;
            frame        <= '0;
            nbytes       <= '0;
            spi_response <= 8'h00;
            spi_avail    <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            spi_avail <= byte_done;
            if (byte_done) spi_response <= {sh_q[6:0], card_MISO};
            if (accept) begin
                frame  <= spi_cmd_data[CMD_BITS-9:0];
                nbytes <= spi_bytes_expected;
            end else if (state == SEND && sh_last) frame <= {frame[CMD_BITS-17:0], 8'h00};
        end
    end
endmodule

// File: tb/tb_sd_spi_out_init.sv
// tb_sd_spi_out_init: randomized self-checking bench with a behavioural SD card and transaction model
module tb_sd_spi_out_init;
    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic [47:0] spi_cmd_data = '0;
    logic        spi_cmd = 1'b0;
    logic [9:0]  spi_bytes_expected = '0;
    logic        spi_busy, spi_error, spi_avail, card_MOSI, card_CS;
    logic [7:0]  spi_response;
    logic        card_MISO = 1'b1;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          held_prev = 0;

    sd_spi_out_init dut (
        .clk                (clk),
        .res_n              (res_n),
        .spi_cmd_data       (spi_cmd_data),
        .spi_cmd            (spi_cmd),
        .spi_bytes_expected (spi_bytes_expected),
        .spi_busy           (spi_busy),
        .spi_error          (spi_error),
        .spi_response       (spi_response),
        .spi_avail          (spi_avail),
        .card_MOSI          (card_MOSI),
        .card_MISO          (card_MISO),
        .card_CS            (card_CS)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // power-up phase: busy, CS and MOSI high for exactly 80 clocks
    task automatic init_count();
        int n = 0;
        int bad = 0;
        while (spi_busy && n < 500) begin
            if (!card_CS || !card_MOSI) bad++;
            n++;
            @(negedge clk);
        end
        check("init_len", n, 80);
        check("init_cs_mosi", bad, 0);
        check("idle_cs", card_CS, 1);
    endtask

    // one command: card answers after 'delay' ones with nb bytes (dval<0: random bytes)
    task automatic txn(input logic [47:0] frame, input int nb, input int delay, input int dval,
                       input logic fill, input bit hold);
        logic [7:0]  exp_q[$];
        logic [7:0]  got_q[$];
        bit          mq[$];
        logic [7:0]  v;
        logic [47:0] tx = '0;
        bit          to;
        int          exp_low, w, lowcnt, tailn, cyc, mosi_bad;
        w = 0; lowcnt = 0; tailn = 0; cyc = 0; mosi_bad = 0;
        for (int i = 0; i < delay; i++) mq.push_back(1'b1);
        for (int b = 0; b < nb; b++) begin
            v = dval >= 0 ? 8'(dval) : b == 0 ? 8'($urandom_range(1, 127)) : 8'($urandom_range(0, 255));
            exp_q.push_back(v);
            for (int k = 7; k >= 0; k--) mq.push_back(v[k]);
        end
`ifdef SD_SPI_TIMEOUT_EN
        to = nb != 0 && delay >= 64;
`else
        to = 0;
`endif
        if (to) exp_q.delete();
        exp_low = nb == 0 ? 48 : to ? 48 + 64 : 48 + delay + 8 * nb;
        while (spi_busy && w < 1000) begin
            w++;
            @(negedge clk);
        end
        if (held_prev) check("b2b_no_idle_wait", w, 0);
        else check("start_idle", spi_busy, 0);
        card_MISO = fill;
        spi_cmd_data = frame;
        spi_bytes_expected = 10'(nb);
        spi_cmd = 1'b1;
        @(negedge clk);
        if (!hold) spi_cmd = 1'b0;
        held_prev = hold;
        check("accept_cs_low", card_CS, 0);
        check("error_cleared", spi_error, 0);
        while (cyc < 3000) begin
            if (!card_CS) begin
                lowcnt++;
                if (lowcnt <= 48) tx = {tx[46:0], card_MOSI};
                else if (!card_MOSI) mosi_bad++;
            end else if (spi_busy) tailn++;
            else break;
            if (spi_avail) got_q.push_back(spi_response);
            card_MISO = (!card_CS && lowcnt >= 49) ? (mq.size() > 0 ? mq.pop_front() : fill) : fill;
            @(negedge clk);
            cyc++;
        end
        check("txn_bounded", cyc < 3000, 1);
        check("mosi_frame", tx, frame);
        check("mosi_high_rx", mosi_bad, 0);
        check("cs_low_len", lowcnt, exp_low);
        check("tail_len", tailn, 8);
        check("avail_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("resp_byte", got_q[i], exp_q[i]);
        check("error_flag", spi_error, to);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] f;
        repeat (3) @(negedge clk);
        check("rst_cs", card_CS, 1);
        check("rst_mosi", card_MOSI, 1);
        check("rst_busy", spi_busy, 1);
        check("rst_err", spi_error, 0);
        check("rst_avail", spi_avail, 0);
        check("rst_resp", spi_response, 0);
        res_n = 1'b1;
        init_count();
        txn(48'h40_0000_0000_95, 1, 24, 1, 1'b1, 0);
        check("cmd0_resp", spi_response, 8'h01);
        for (int t = 0; t < 8; t++) begin
            f = {16'($urandom), 32'($urandom)};
            f[47:46] = 2'b01;
            f[0] = 1'b1;
            txn(f, $urandom_range(0, 4), $urandom_range(0, 40), -1, 1'b1, 0);
        end
        txn(48'h51_0000_0000_55, 6, 0, 0, 1'b0, 0);
        txn(48'h48_0000_01AA_87, 0, 0, -1, 1'b1, 0);
        txn(48'h77_0000_0000_65, 1, 63, -1, 1'b1, 0);
        txn(48'h69_4000_0000_77, 1, 64, -1, 1'b1, 0);
`ifndef SD_SPI_TIMEOUT_EN
        txn(48'h69_4000_0000_77, 2, 100, -1, 1'b1, 0);
`endif
        txn(48'h7A_0000_0000_FD, 1, 5, -1, 1'b1, 0);
        check("err_cleared_after", spi_error, 0);
        txn(48'h4C_0000_0200_15, 2, 3, -1, 1'b1, 1);
        txn(48'h50_0000_0200_15, 1, 2, -1, 1'b1, 0);
        check("resp_nonzero_pre_rst", spi_response != 8'h00, 1);
        spi_cmd_data = 48'h0;
        spi_bytes_expected = 10'd1;
        spi_cmd = 1'b1;
        @(negedge clk);
        spi_cmd = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_send_cs", card_CS, 0);
        check("mid_send_mosi", card_MOSI, 0);
        res_n = 1'b0;
        #1;
        check("async_rst_cs", card_CS, 1);
        check("async_rst_mosi", card_MOSI, 1);
        check("async_rst_busy", spi_busy, 1);
        check("async_rst_resp", spi_response, 0);
        check("async_rst_avail", spi_avail, 0);
        @(negedge clk);
        res_n = 1'b1;
        init_count();
        txn(48'h40_0000_0000_95, 1, 8, 1, 1'b1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_spi_out_init.md
SD_SPI_OUT_INIT -- requirements
Module: sd_spi_out_init

Interface
REQ-001 Parameter INIT_CLKS, default 80, count of power-up clocks with CS and MOSI high (minimum 74).
REQ-002 Parameter NCR_MAX, default 8, maximum response-wait bytes (8 clocks each) before timeout.
REQ-003 clk  in  1  SPI bit clock; all logic on rising edge; the same net drives the card SCLK.
REQ-004 res_n  in  1  asynchronous, active-low reset.
REQ-005 spi_cmd_data  in  48  command frame, sent MSB first (start bit, cmd, arg, CRC).
REQ-006 spi_cmd  in  1  command request, level-sensitive.
REQ-007 spi_bytes_expected  in  10  response bytes to capture (0..1023).
REQ-008 spi_busy  out  1  high during init and during any transaction.
REQ-009 spi_error  out  1  response timeout flag.
REQ-010 spi_response  out  8  last received response byte.
REQ-011 spi_avail  out  1  one-cycle strobe: spi_response valid.
REQ-012 card_MOSI  out  1  serial data to card.
REQ-013 card_MISO  in  1  serial data from card.
REQ-014 card_CS  out  1  chip select, active low.

Function
REQ-015 States: INIT, IDLE, SEND, WAIT_R, RECV, TAIL.
REQ-016 INIT: CS=1, MOSI=1, busy=1 for INIT_CLKS clocks, then go to IDLE.
REQ-017 IDLE: busy=0, CS=1, MOSI=1; spi_cmd=1 latches data and byte count, clears spi_error, and enters SEND on the next edge.
REQ-018 While busy, spi_cmd is ignored; holding it high issues back-to-back transactions.
REQ-019 SEND: CS=0; shift 48 bits MSB first, one bit per clock, over exactly 48 clocks.
REQ-020 After SEND: if the latched count is 0, go to TAIL; otherwise go to WAIT_R with MOSI=1.
REQ-021 WAIT_R: sample MISO each clock; the first 0 is bit 7 of byte 1; enter RECV.
REQ-022 RECV: assemble bytes MSB first; each byte completes on the 8th bit, where spi_response updates and spi_avail pulses for 1 cycle.
REQ-023 The received-byte count is 10 bits; after the count-th byte, go to TAIL.
REQ-024 Timeout: 8*NCR_MAX clocks in WAIT_R without a 0 set spi_error=1, abort the transaction, and go to TAIL.
REQ-025 spi_error holds until the next accepted command or reset.
REQ-026 TAIL: CS=1, MOSI=1 for 8 clocks, then go to IDLE.

Reset
REQ-027 Reset (asynchronous, mid-operation included) aborts any transfer and re-enters INIT.
REQ-028 Reset output values: card_CS=1, card_MOSI=1, spi_busy=1, spi_error=0, spi_avail=0, spi_response=0x00.

Configuration
REQ-029 With SD_SPI_TIMEOUT_EN defined, REQ-024 applies.
REQ-030 Without SD_SPI_TIMEOUT_EN, WAIT_R waits indefinitely and spi_error is tied to 0.

Structure
REQ-031 Package sd_spi_pkg holds the state enum, CMD_BITS=48, and the default constants for INIT_CLKS and NCR_MAX.
REQ-032 One sub-module, sd_spi_shift, provides an 8-bit shift register with bit counter, used for both TX and RX.
REQ-033 The clock comes from sibling sd_clk_gen: free-running 8-bit counter clk_out[7:0]; clk_out[7] = clk/256.

Verification
REQ-034 Release reset, MISO=1 -> CS=1, MOSI=1, busy=1 for exactly 80 clocks, then busy=0.
REQ-035 spi_cmd=1, data 48'h40_0000_0000_95, bytes=1, card answers 0x01 after 3 idle bytes -> MOSI bit sequence matches the frame, response=0x01, one avail pulse, CS high after 8 tail clocks.
REQ-036 spi_cmd=1, bytes=6, MISO=0 throughout -> six avail pulses, each with response=0x00, then IDLE.
REQ-037 spi_cmd=1, bytes=1, MISO=1 throughout, macro defined -> spi_error=1 after 64 WAIT_R clocks, no avail pulse, CS high; a new command clears the error.
REQ-038 Assert res_n=0 mid-SEND -> CS=1, MOSI=1 immediately, INIT repeats.
REQ-039 spi_cmd held high for 2 transactions -> back-to-back frames separated by 8 tail clocks.
